cacheline_adapter: RTL and testbench

- Responder on the cache downward-facing port (dfp_*): accepts one 256-bit line read or writeback from a cache and services it as a 4-beat, 64-bit burst on the banked-memory (bmem_*) interface.
- Sits between each cache (or the cache arbiter) and main memory.
- One request is in flight at a time; dfp_resp completes each request.

---
 rtl/cacheline_adapter_pkg.sv | 20 ++
 rtl/cacheline_adapter.sv | 156 +++++++++++++++
 tb/tb_cacheline_adapter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adapter_pkg.sv
// Shared types for the cacheline adapter: burst FSM states, line/beat geometry
// and the cacheline container type.
package cache_types;

  localparam int CACHELINE_BITS = 256;
  localparam int BEAT_BITS      = 64;
  localparam int BURST_LEN      = 4;
  localparam int ADDR_BITS      = 32;

  typedef logic [CACHELINE_BITS-1:0] line_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_WR,
    ST_RESP
  } state_e;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one 256-bit cache line read/writeback on the dfp_* port into a
// 4-beat, 64-bit burst on the banked-memory (bmem_*) port, one request at a time.
module cacheline_adapter
  import cache_types::*;
#(
  parameter int BEAT_BITS = cache_types::BEAT_BITS,
  parameter int BURST_LEN = cache_types::BURST_LEN,
  parameter int ADDR_BITS = cache_types::ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic [ADDR_BITS-1:0] dfp_addr,
  input  logic                 dfp_read,
  input  logic                 dfp_write,
  input  line_t                dfp_wdata,
  output line_t                dfp_rdata,
  output logic                 dfp_resp,

  output logic [ADDR_BITS-1:0] bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [ADDR_BITS-1:0] bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);

  localparam int                   CNT_W       = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0]     LAST_BEAT   = CNT_W'(BURST_LEN - 1);
  localparam int                   OFFSET_BITS = $clog2(CACHELINE_BITS / 8);
  localparam logic [ADDR_BITS-1:0] LINE_MASK   =
    ~ADDR_BITS'((64'd1 << OFFSET_BITS) - 64'd1);

  if (BEAT_BITS * BURST_LEN != CACHELINE_BITS) begin : g_bad_geometry
    $error("cacheline_adapter: BEAT_BITS*BURST_LEN must equal CACHELINE_BITS");
  end

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  line_t                  wline_q, wline_d;
  line_t                  rdata_q, rdata_d;

  logic                   raddr_match;
  assign raddr_match = (bmem_raddr == addr_q);

  // Next-state logic. Write wins when both requests are raised together.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (dfp_write || dfp_read) begin
          addr_d  = dfp_addr & LINE_MASK;
          wline_d = dfp_wdata;
          cnt_d   = '0;
          state_d = dfp_write ? ST_WR : ST_RD_CMD;
        end
      end

      ST_RD_CMD: begin
        if (bmem_ready) begin
          cnt_d   = '0;
          state_d = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        // Beats tagged with another address belong to someone else; drop them.
        if (bmem_rvalid && raddr_match) begin
          rdata_d[int'(cnt_q)*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = ST_RESP;
        end
      end

      ST_WR: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = ST_RESP;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode from state only, so reset clears them asynchronously.
  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    dfp_resp   = 1'b0;

    unique case (state_q)
      ST_RD_CMD: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
      end
      ST_WR: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = wline_q[int'(cnt_q)*BEAT_BITS +: BEAT_BITS];
      end
      ST_RESP: dfp_resp = 1'b1;
      default: ;
    endcase
  end

  assign dfp_rdata = rdata_q;

  // Protocol sanity checks; the design keeps working when they fire.
  always @(posedge clk) begin
    if (rst_n) begin
      if (state_q == ST_IDLE)
        assert (!(dfp_read && dfp_write))
          else $warning("cacheline_adapter: dfp_read and dfp_write together, servicing write");
      if (state_q == ST_RD_DATA && bmem_rvalid)
        assert (raddr_match)
          else $warning("cacheline_adapter: read beat raddr %h does not match %h, ignored",
                        bmem_raddr, addr_q);
      assert (!(bmem_read && bmem_write))
        else $error("cacheline_adapter: bmem_read and bmem_write high together");
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: stimulus pushes expected bmem commands,
// write beats and dfp responses; a negedge monitor pops and compares them.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  dfp_addr;
  logic         dfp_read, dfp_write;
  logic [255:0] dfp_wdata, dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr, bmem_raddr;
  logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0]  bmem_wdata, bmem_rdata;

  cacheline_adapter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  typedef enum int { EV_CMD, EV_WBEAT, EV_RESP } ev_kind_e;
  typedef struct {
    ev_kind_e     kind;
    logic [31:0]  addr;
    logic [255:0] data;
  } ev_t;

  ev_t          exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [255:0] last_line;   // expected dfp_rdata contents

  localparam logic [255:0] ASC_LINE =
    256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [255:0] ABCD_LINE =
    256'hdddddddddddddddd_cccccccccccccccc_bbbbbbbbbbbbbbbb_aaaaaaaaaaaaaaaa;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_ev(input ev_kind_e kind, input logic [31:0] addr,
                                  input logic [255:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  // Monitor: one observable event per cycle at most (states are exclusive).
  always @(negedge clk) begin
    if (rst_n) begin
      ev_t got, exp;
      bit  seen;
      seen = 1'b0;
      if (bmem_read && bmem_ready) begin
        got = '{EV_CMD, bmem_addr, 256'd0}; seen = 1'b1;
      end else if (bmem_write && bmem_ready) begin
        got = '{EV_WBEAT, bmem_addr, {192'd0, bmem_wdata}}; seen = 1'b1;
      end else if (dfp_resp) begin
        got = '{EV_RESP, 32'd0, dfp_rdata}; seen = 1'b1;
      end
      if (seen) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d addr %h, expected no event",
                   got.kind, got.addr);
        end else begin
          exp = exp_q.pop_front();
          check("ev_kind", 256'(got.kind), 256'(exp.kind));
          check("ev_addr", {224'd0, got.addr}, {224'd0, exp.addr});
          check("ev_data", got.data, exp.data);
        end
      end
    end
  end

  // Count negedges until dfp_resp is seen; n = -1 on timeout.
  task automatic wait_resp(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (dfp_resp) begin
        n = i;
        break;
      end
    end
    if (n < 0) check("resp_timeout", 256'd0, 256'd1);
  endtask

  task automatic finish_req();
    @(posedge clk); #1;
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    @(negedge clk);
    check("resp_one_cycle", {255'd0, dfp_resp}, 256'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [63:0] b0, b1, b2, b3, input logic [255:0] exp_line,
                         input int g0, g1, g2, g3, input int stray_before);
    logic [63:0] beats[4];
    int          gaps[4];
    int          m;
    beats = '{b0, b1, b2, b3};
    gaps  = '{g0, g1, g2, g3};
    @(posedge clk); #1;
    dfp_addr = addr;
    dfp_read = 1'b1;
    push_ev(EV_CMD, exp_addr, 256'd0);
    push_ev(EV_RESP, 32'd0, exp_line);
    last_line = exp_line;
    @(posedge clk);   // accept
    @(posedge clk);   // command taken
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        #1;
        if (i == stray_before && g == 0) begin
          bmem_rvalid = 1'b1;
          bmem_raddr  = 32'hdead_bee0;
          bmem_rdata  = 64'hbad0_bad0_bad0_bad0;
        end else begin
          bmem_rvalid = 1'b0;
        end
        @(posedge clk);
      end
      #1;
      bmem_rvalid = 1'b1;
      bmem_raddr  = exp_addr;
      bmem_rdata  = beats[i];
      @(posedge clk);
    end
    #1 bmem_rvalid = 1'b0;
    wait_resp(m);
    check("rd_resp_latency", 256'(m), 256'd1);
    finish_req();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [255:0] line, input logic [63:0] b0, b1, b2, b3,
                          input int stall_beat, input int stall_cycles, input bit both);
    logic [63:0] beats[4];
    int          n, m;
    beats = '{b0, b1, b2, b3};
    @(posedge clk); #1;
    dfp_addr  = addr;
    dfp_wdata = line;
    dfp_write = 1'b1;
    dfp_read  = both;
    for (int k = 0; k < 4; k++) push_ev(EV_WBEAT, exp_addr, {192'd0, beats[k]});
    push_ev(EV_RESP, 32'd0, last_line);
    @(posedge clk);   // accept
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == stall_beat) begin
        for (int s = 0; s < stall_cycles; s++) begin
          #1 bmem_ready = 1'b0;
          @(negedge clk);
          check("stall_write_held", {255'd0, bmem_write}, 256'd1);
          check("stall_beat_held", {192'd0, bmem_wdata}, {192'd0, beats[k]});
          @(posedge clk);
          n++;
        end
      end
      #1 bmem_ready = 1'b1;
      @(posedge clk);
      n++;
    end
    wait_resp(m);
    check("wr_resp_cycle", 256'(n + m), 256'(5 + stall_cycles));
    finish_req();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    dfp_addr    = '0;
    dfp_read    = 1'b0;
    dfp_write   = 1'b0;
    dfp_wdata   = '0;
    bmem_ready  = 1'b1;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    bmem_rvalid = 1'b0;
    last_line   = '0;

    #3;
    check("rst_bmem_read",  {255'd0, bmem_read},  256'd0);
    check("rst_bmem_write", {255'd0, bmem_write}, 256'd0);
    check("rst_bmem_addr",  {224'd0, bmem_addr},  256'd0);
    check("rst_dfp_resp",   {255'd0, dfp_resp},   256'd0);
    check("rst_dfp_rdata",  dfp_rdata,            256'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {254'd0, bmem_read, bmem_write}, 256'd0);

    // Plain read, unaligned address is forced to line alignment.
    do_read(32'h0000_1234, 32'h0000_1220,
            64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
            0, 0, 0, 0, -1);

    // Plain write of ascending bytes; dfp_rdata must keep the previous read line.
    do_write(32'h8000_0040, 32'h8000_0040, ASC_LINE,
             64'h0706050403020100, 64'h0f0e0d0c0b0a0908,
             64'h1716151413121110, 64'h1f1e1d1c1b1a1918, -1, 0, 1'b0);
    check("wr_rdata_kept", dfp_rdata,
          256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Write with memory stalling beat 1 for three cycles.
    do_write(32'h0000_2000, 32'h0000_2000, ABCD_LINE,
             64'haaaa_aaaa_aaaa_aaaa, 64'hbbbb_bbbb_bbbb_bbbb,
             64'hcccc_cccc_cccc_cccc, 64'hdddd_dddd_dddd_dddd, 1, 3, 1'b0);

    // Read with rvalid gaps and a stray beat for another address.
    do_read(32'h0000_3000, 32'h0000_3000,
            64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
            64'h0f0f_0f0f_0f0f_0f0f, 64'hf0f0_f0f0_f0f0_f0f0,
            256'hf0f0f0f0f0f0f0f0_0f0f0f0f0f0f0f0f_fedcba9876543210_0123456789abcdef,
            2, 3, 0, 3, 1);

    // Read and write together: write wins, no read command expected.
    do_write(32'h0000_0100, 32'h0000_0100, ASC_LINE,
             64'h0706050403020100, 64'h0f0e0d0c0b0a0908,
             64'h1716151413121110, 64'h1f1e1d1c1b1a1918, -1, 0, 1'b1);

    // Reset asserted while beat 2 of a write is on the bus.
    @(posedge clk); #1;
    dfp_addr  = 32'h0000_4000;
    dfp_wdata = ASC_LINE;
    dfp_write = 1'b1;
    push_ev(EV_WBEAT, 32'h0000_4000, {192'd0, 64'h0706050403020100});
    push_ev(EV_WBEAT, 32'h0000_4000, {192'd0, 64'h0f0e0d0c0b0a0908});
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_beat2", {192'd0, bmem_wdata}, {192'd0, 64'h1716151413121110});
    #1 rst_n = 1'b0;
    dfp_write = 1'b0;
    #1;
    check("midrst_bmem_write", {255'd0, bmem_write}, 256'd0);
    check("midrst_bmem_read",  {255'd0, bmem_read},  256'd0);
    check("midrst_bmem_addr",  {224'd0, bmem_addr},  256'd0);
    check("midrst_bmem_wdata", {192'd0, bmem_wdata}, 256'd0);
    check("midrst_dfp_resp",   {255'd0, dfp_resp},   256'd0);
    check("midrst_dfp_rdata",  dfp_rdata,            256'd0);
    check("midrst_pending",    256'(exp_q.size()),   256'd0);
    last_line = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_read(32'h0000_5010, 32'h0000_5000,
            64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
            64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888,
            256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555,
            0, 1, 0, 0, -1);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
